// File: rtl/inst_aligner_pkg.sv
// Shared constants and length-decode helper for the instruction aligner.
package inst_aligner_pkg;

  localparam logic [1:0] ILEN_16    = 2'd1;   // halfwords consumed by an RVC instruction
  localparam logic [1:0] ILEN_32    = 2'd2;   // halfwords consumed by a 32-bit instruction
  localparam logic [1:0] RVC_OPMASK = 2'b11;
  localparam logic [2:0] OPLEN_GT32 = 3'b111;

  function automatic logic is_32b(input logic [15:0] h);
    return h[1:0] == RVC_OPMASK;
  endfunction

endpackage

// File: rtl/inst_aligner_if.sv
// Fetch-side, redirect and decoder-side signals of the aligner.
interface inst_aligner_if #(parameter int XLEN = 32);
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [31:0]     fetch_data;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_rvc;
  logic            out_illegal;

  modport master (
    output flush, flush_pc, fetch_valid, fetch_data, out_ready,
    input  fetch_ready, out_valid, out_inst, out_pc, out_rvc, out_illegal
  );

  modport slave (
    input  flush, flush_pc, fetch_valid, fetch_data, out_ready,
    output fetch_ready, out_valid, out_inst, out_pc, out_rvc, out_illegal
  );
endinterface

// File: rtl/inst_aligner_hw_queue.sv
// Halfword circular buffer: 0/1/2 pushes and 0/1/2 pops per cycle, any even DEPTH.
module hw_queue #(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_i,
  input  logic [1:0]    push_n_i,
  input  logic [15:0]   push_d0_i,
  input  logic [15:0]   push_d1_i,
  input  logic [1:0]    pop_n_i,
  output logic [CW-1:0] count_o,
  output logic [15:0]   h0_o,
  output logic [15:0]   h1_o
);

  logic [15:0]   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW-1){1'b0}}, n};
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  always_comb begin
    head_d  = wrap_add(head_q, pop_n_i);
    tail_d  = wrap_add(tail_q, push_n_i);
    count_d = count_q + CW'(push_n_i) - CW'(pop_n_i);
  end

  always_ff @(posedge clock) begin
    if (reset || clr_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_n_i != 2'd0) mem_q[tail_q] <= push_d0_i;
    if (push_n_i == 2'd2) mem_q[wrap_add(tail_q, 2'd1)] <= push_d1_i;
  end

  assign count_o = count_q;
  assign h0_o    = mem_q[head_q];
  assign h1_o    = mem_q[wrap_add(head_q, 2'd1)];

endmodule

// File: rtl/inst_aligner.sv
// Re-aligns 32-bit fetch words holding mixed RVC/32-bit code into one instruction per cycle.
module inst_aligner
  import inst_aligner_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  inst_aligner_if.slave    bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   count;
  logic [15:0]     h0, h1, d0;
  logic            is32, out_valid, out_rvc, fetch_ready, push, pop;
  logic [1:0]      push_n, pop_n;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_low_q, drop_low_d;
  logic            unused_pc0;

  assign unused_pc0 = bus.flush_pc[0];

  hw_queue #(.DEPTH(DEPTH)) u_q (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (bus.flush),
    .push_n_i (push_n),
    .push_d0_i(d0),
    .push_d1_i(bus.fetch_data[31:16]),
    .pop_n_i  (pop_n),
    .count_o  (count),
    .h0_o     (h0),
    .h1_o     (h1)
  );

  always_comb begin
    is32        = is_32b(h0);
    out_valid   = is32 ? (count >= CW'(2)) : (count >= CW'(1));
    out_rvc     = out_valid && !is32;
    fetch_ready = count <= CW'(DEPTH - 2);
    // Flush wins: nothing is enqueued or retired in a redirect cycle.
    push        = bus.fetch_valid && fetch_ready && !bus.flush;
    pop         = out_valid && bus.out_ready && !bus.flush;
    push_n      = push ? (drop_low_q ? ILEN_16 : ILEN_32) : 2'd0;
    d0          = drop_low_q ? bus.fetch_data[31:16] : bus.fetch_data[15:0];
    pop_n       = pop ? (is32 ? ILEN_32 : ILEN_16) : 2'd0;
    pc_d        = pc_q;
    drop_low_d  = drop_low_q;
    if (bus.flush) begin
      pc_d       = {bus.flush_pc[XLEN-1:1], 1'b0};
      drop_low_d = bus.flush_pc[1];
    end else begin
      if (pop)  pc_d       = pc_q + (is32 ? XLEN'(4) : XLEN'(2));
      if (push) drop_low_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      drop_low_q <= RESET_PC[1];
    end else begin
      pc_q       <= pc_d;
      drop_low_q <= drop_low_d;
    end
  end

  assign bus.fetch_ready = fetch_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_rvc     = out_rvc;
  assign bus.out_inst    = is32 ? {h1, h0} : {16'h0000, h0};
  assign bus.out_pc      = pc_q;
  assign bus.out_illegal = out_valid && ((out_rvc && h0 == 16'h0000) ||
                                         (!out_rvc && h0[4:2] == OPLEN_GT32));

endmodule

// File: tb/tb_inst_aligner.sv
// Self-checking bench for inst_aligner: vector table feeding a scoreboard, plus corner sequences.
module tb_inst_aligner;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        rvc;
    logic        ill;
  } exp_t;

  typedef struct {
    bit          fl;
    logic [31:0] fpc;
    logic [31:0] word;
    int          n;
    exp_t        e0;
    exp_t        e1;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  bit   accepted;
  exp_t sb[$];
  vec_t tbl[11];

  inst_aligner_if #(.XLEN(32)) bus ();

  inst_aligner #(.XLEN(32), .DEPTH(8), .RESET_PC(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t e(input logic [31:0] inst, input logic [31:0] pc,
                             input logic rvc, input logic ill);
    exp_t r;
    r.inst = inst; r.pc = pc; r.rvc = rvc; r.ill = ill;
    return r;
  endfunction

  function automatic vec_t v(input bit fl, input logic [31:0] fpc, input logic [31:0] word,
                             input int n, input exp_t e0, input exp_t e1);
    vec_t r;
    r.fl = fl; r.fpc = fpc; r.word = word; r.n = n; r.e0 = e0; r.e1 = e1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, return 1ns after the rising edge.
  task automatic cycle();
    exp_t x;
    @(negedge clock);
    accepted = bus.fetch_valid && bus.fetch_ready && !bus.flush && !reset;
    if (!reset && !bus.flush && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got inst %h pc %h expected no output",
                 bus.out_inst, bus.out_pc);
      end else begin
        x = sb.pop_front();
        chk("out_inst", bus.out_inst, x.inst);
        chk("out_pc", bus.out_pc, x.pc);
        chk("out_rvc", 32'(bus.out_rvc), 32'(x.rvc));
        chk("out_illegal", 32'(bus.out_illegal), 32'(x.ill));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = w;
    accepted = 1'b0;
    while (!accepted && n < 50) begin
      cycle();
      n++;
    end
    bus.fetch_valid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: word %h not accepted within 50 cycles", w);
    end
  endtask

  task automatic flush_cyc(input logic [31:0] fpc, input logic [31:0] w);
    bus.flush       = 1'b1;
    bus.flush_pc    = fpc;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = w;
    cycle();
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      cycle();
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b1;
    bus.flush       = 1'b0;
    bus.flush_pc    = '0;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = '0;
    bus.out_ready   = 1'b0;

    tbl[0]  = v(0, 0, 32'h0001_4501, 2, e(32'h4501, 32'h4, 1, 0), e(32'h0001, 32'h6, 1, 0));
    tbl[1]  = v(0, 0, 32'h0093_4501, 1, e(32'h4501, 32'h8, 1, 0), e(0, 0, 0, 0));
    tbl[2]  = v(0, 0, 32'h1234_0000, 2, e(32'h0000_0093, 32'hA, 0, 0), e(32'h1234, 32'hE, 1, 0));
    tbl[3]  = v(1, 32'h102, 32'hFFFF_FFFF, 0, e(0, 0, 0, 0), e(0, 0, 0, 0));
    tbl[4]  = v(0, 0, 32'h0013_1111, 0, e(0, 0, 0, 0), e(0, 0, 0, 0));
    tbl[5]  = v(0, 0, 32'hAAAA_0000, 2, e(32'h13, 32'h102, 0, 0), e(32'hAAAA, 32'h106, 1, 0));
    tbl[6]  = v(0, 0, 32'h0000_001F, 1, e(32'h1F, 32'h108, 0, 1), e(0, 0, 0, 0));
    tbl[7]  = v(0, 0, 32'h0001_0000, 2, e(32'h0, 32'h10C, 1, 1), e(32'h1, 32'h10E, 1, 0));
    tbl[8]  = v(1, 32'hFFFF_FFFC, 32'h0000_0013, 0, e(0, 0, 0, 0), e(0, 0, 0, 0));
    tbl[9]  = v(0, 0, 32'h0000_0013, 1, e(32'h13, 32'hFFFF_FFFC, 0, 0), e(0, 0, 0, 0));
    tbl[10] = v(0, 0, 32'h0001_0001, 2, e(32'h1, 32'h0, 1, 0), e(32'h1, 32'h2, 1, 0));

    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_rvc", 32'(bus.out_rvc), 32'd0);
    chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    chk("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    chk("rst_out_pc", bus.out_pc, 32'h0);

    // First-word latency: valid right after the accepting edge.
    sb.push_back(e(32'h13, 32'h0, 0, 0));
    push_word(32'h0000_0013);
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_inst", bus.out_inst, 32'h13);
    chk("lat_pc", bus.out_pc, 32'h0);
    chk("lat_rvc", 32'(bus.out_rvc), 32'd0);
    bus.out_ready = 1'b1;
    cycle();
    chk("after_pop_valid", 32'(bus.out_valid), 32'd0);
    chk("after_pop_pc", bus.out_pc, 32'h4);

    foreach (tbl[i]) begin
      if (tbl[i].fl) begin
        drain();
        flush_cyc(tbl[i].fpc, tbl[i].word);
        chk("flush_pc", bus.out_pc, {tbl[i].fpc[31:1], 1'b0});
      end else begin
        if (tbl[i].n > 0) sb.push_back(tbl[i].e0);
        if (tbl[i].n > 1) sb.push_back(tbl[i].e1);
        push_word(tbl[i].word);
      end
    end
    drain();

    // Backpressure: fill the queue with out_ready low, then release.
    flush_cyc(32'h200, 32'h0);
    bus.out_ready = 1'b0;
    sb.push_back(e(32'h4501, 32'h200, 1, 0));
    sb.push_back(e(32'h13, 32'h202, 0, 0));
    sb.push_back(e(32'h0, 32'h206, 1, 1));
    sb.push_back(e(32'h1, 32'h208, 1, 0));
    sb.push_back(e(32'h1, 32'h20A, 1, 0));
    sb.push_back(e(32'hBEEF_0093, 32'h20C, 0, 0));
    sb.push_back(e(32'h1, 32'h210, 1, 0));
    sb.push_back(e(32'h0, 32'h212, 1, 1));
    push_word(32'h0013_4501);
    push_word(32'h0000_0000);
    push_word(32'h0001_0001);
    push_word(32'hBEEF_0093);
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = 32'h0000_0001;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_blocked", 32'(accepted), 32'd0);
      chk("bp_ready", 32'(bus.fetch_ready), 32'd0);
      chk("bp_hold_inst", bus.out_inst, 32'h4501);
      chk("bp_hold_pc", bus.out_pc, 32'h200);
    end
    bus.out_ready = 1'b1;
    begin
      int n;
      n = 0;
      accepted = 1'b0;
      while (!accepted && n < 50) begin
        cycle();
        n++;
      end
      bus.fetch_valid = 1'b0;
      chk("bp_accept", 32'(accepted), 32'd1);
    end
    drain();

    // Flush with a pending instruction, fetch_valid and out_ready all high.
    bus.out_ready = 1'b0;
    push_word(32'h0000_0013);
    bus.out_ready = 1'b1;
    flush_cyc(32'h300, 32'h0001_0001);
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_pc", bus.out_pc, 32'h300);
    chk("fl_ready", 32'(bus.fetch_ready), 32'd1);
    sb.push_back(e(32'h1, 32'h300, 1, 0));
    sb.push_back(e(32'h1, 32'h302, 1, 0));
    push_word(32'h0001_0001);
    drain();
    chk("final_pc", bus.out_pc, 32'h304);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
